// File: rtl/alu_pkg.sv
// Shared definitions for the ALU request arbiter: op encodings, FSM states
// and default sizing.
package alu_pkg;

    localparam int unsigned N_REQ_DEF   = 4;
    localparam int unsigned TIMEOUT_DEF = 8;

    typedef enum logic [2:0] {
        OP_NOP = 3'd0,
        OP_ADD = 3'd1,
        OP_AND = 3'd2,
        OP_XOR = 3'd3,
        OP_MUL = 3'd4
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } arb_state_e;

    // Encodings above MUL are reserved and answered with an error.
    function automatic logic op_legal(input logic [2:0] op);
        return op <= OP_MUL;
    endfunction

endpackage

// File: rtl/alu_req_arbiter_rr_pick.sv
// Round-robin picker: first requester above last_grant, wrapping around.
module rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    last_grant,
    output logic [IW-1:0]    grant,
    output logic             any_req
);

    logic [IW-1:0] cand;

    always_comb begin
        grant   = '0;
        any_req = 1'b0;
        cand    = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = IW'((32'(last_grant) + k) % N_REQ);
            if (!any_req && req[cand]) begin
                any_req = 1'b1;
                grant   = cand;
            end
        end
    end

endmodule

// File: rtl/alu_req_arbiter.sv
// Arbitrates N_REQ requesters onto one shared ALU; one operation in flight,
// round-robin grant, timeout on a silent ALU, all outputs registered.
module alu_req_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned N_REQ   = N_REQ_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req,
    input  logic [3*N_REQ-1:0] req_op,
    input  logic [8*N_REQ-1:0] req_a,
    input  logic [8*N_REQ-1:0] req_b,
    output logic [N_REQ-1:0]   rsp_valid,
    output logic [15:0]        rsp_result,
    output logic               rsp_err,
    output logic               busy,
    output logic               alu_start,
    output logic [2:0]         alu_op,
    output logic [7:0]         alu_a,
    output logic [7:0]         alu_b,
    input  logic               alu_done,
    input  logic [15:0]        alu_result
);

    localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    arb_state_e state_q, state_d;
    logic [IW-1:0]    gnt_q, gnt_d;
    logic [IW-1:0]    last_q, last_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2:0]       op_d;
    logic [7:0]       a_d, b_d;
    logic [N_REQ-1:0] rsp_valid_d;
    logic [15:0]      rsp_result_d;
    logic             rsp_err_d, alu_start_d;

    logic [IW-1:0]    pick_idx;
    logic             any_req;
    logic [2:0]       sel_op;
    logic [7:0]       sel_a, sel_b;
    logic [N_REQ-1:0] pick_oh, gnt_oh;

    rr_pick #(
        .N_REQ(N_REQ),
        .IW   (IW)
    ) u_pick (
        .req       (req),
        .last_grant(last_q),
        .grant     (pick_idx),
        .any_req   (any_req)
    );

    always_comb begin
        sel_op  = '0;
        sel_a   = '0;
        sel_b   = '0;
        pick_oh = '0;
        gnt_oh  = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            pick_oh[i] = (pick_idx == IW'(i));
            gnt_oh[i]  = (gnt_q == IW'(i));
            if (pick_idx == IW'(i)) begin
                sel_op = req_op[3*i +: 3];
                sel_a  = req_a[8*i +: 8];
                sel_b  = req_b[8*i +: 8];
            end
        end
    end

    // Outputs are computed one state ahead so they register with the state.
    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        last_d       = last_q;
        cnt_d        = cnt_q;
        op_d         = alu_op;
        a_d          = alu_a;
        b_d          = alu_b;
        rsp_valid_d  = '0;
        rsp_result_d = '0;
        rsp_err_d    = 1'b0;
        alu_start_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    gnt_d  = pick_idx;
                    last_d = pick_idx;
                    op_d   = sel_op;
                    a_d    = sel_a;
                    b_d    = sel_b;
                    if (op_legal(sel_op)) begin
                        state_d     = ST_ISSUE;
                        alu_start_d = 1'b1;
                    end else begin
                        state_d     = ST_RESP;
                        rsp_valid_d = pick_oh;
                        rsp_err_d   = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
                cnt_d   = '0;
            end
            ST_WAIT: begin
                if (alu_done) begin
                    state_d      = ST_RESP;
                    rsp_valid_d  = gnt_oh;
                    rsp_result_d = alu_result;
                end else if (cnt_q == CW'(TIMEOUT)) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = gnt_oh;
                    rsp_err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            gnt_q      <= '0;
            last_q     <= IW'(N_REQ - 1);
            cnt_q      <= '0;
            alu_op     <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            rsp_valid  <= '0;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
            busy       <= 1'b0;
            alu_start  <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            alu_op     <= op_d;
            alu_a      <= a_d;
            alu_b      <= b_d;
            rsp_valid  <= rsp_valid_d;
            rsp_result <= rsp_result_d;
            rsp_err    <= rsp_err_d;
            busy       <= (state_d != ST_IDLE);
            alu_start  <= alu_start_d;
        end
    end

endmodule
